// File: rtl/mul_div_pkg.sv
// mul_div_pkg: shared types for the HI/LO multiply/divide unit.
//   md_op_t    - operation encoding presented on the request bus (6 and 7 are invalid)
//   md_state_t - sequencer states: IDLE, RUN (one bit per cycle), FIN (sign fix + commit)
// Helper functions classify an operation code.
package mul_div_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } md_state_t;

  function automatic logic op_is_valid(input md_op_t op);
    return op <= MD_MTLO;
  endfunction

  function automatic logic op_is_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_mul(input md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/mul_div_if.sv
// mul_div_if: request/result bus between the CPU control path and mul_div_unit.
//   start, op, a, b           - request (driven by master)
//   busy, done, div_zero      - handshake/status (driven by slave)
//   hi, lo                    - architectural HI/LO registers (driven by slave)
// Modports: master (CPU side), slave (mul_div_unit side).
interface mul_div_if #(
  parameter int WIDTH = 32
);
  import mul_div_pkg::*;

  logic             start;
  md_op_t           op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/mul_div_sign_fix.sv
// md_sign_fix: combinational conditional two's-complement negate.
//   value  in  W - input value
//   negate in  1 - when 1, result = -value; otherwise result = value
//   result out W - output value
// The most-negative value negates to itself, which callers rely on when
// treating it as the unsigned magnitude 2^(W-1).
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle HI/LO multiply/divide unit.
//   clk      in  - rising-edge clock
//   reset_n  in  - asynchronous active-low reset
//   bus      slave modport of mul_div_if:
//            start/op/a/b in; busy/done/div_zero/hi/lo out
// Multiplies use radix-2 shift-add, divides use restoring division, one bit
// per cycle over WIDTH RUN cycles followed by a FIN cycle that applies sign
// correction and commits HI/LO. MTHI/MTLO write directly at the accept edge.
// Optional build macro FAST_MULT_EN: MULT/MULTU go straight to FIN using a
// single-cycle WIDTH x WIDTH multiplier.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset_n,
  mul_div_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  md_state_t          state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   acc_hi, acc_lo, opnd;
  logic               is_div_q, b_zero_q, neg_q, neg_r;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               done_r, div_zero_r;

  logic               accept, signed_in, neg_a_in, neg_b_in;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic               div_fits;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] prod_fix, fast_prod;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

`ifdef FAST_MULT_EN
  localparam bit FAST_MULT = 1'b1;
  assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`else
  localparam bit FAST_MULT = 1'b0;
  assign fast_prod = '0;
`endif

  assign accept    = bus.start && (state == IDLE) && op_is_valid(bus.op);
  assign signed_in = op_is_signed(bus.op);
  assign neg_a_in  = signed_in && bus.a[WIDTH-1];
  assign neg_b_in  = signed_in && bus.b[WIDTH-1];

  md_sign_fix #(.W(WIDTH)) u_mag_a (.value(bus.a), .negate(neg_a_in), .result(mag_a));
  md_sign_fix #(.W(WIDTH)) u_mag_b (.value(bus.b), .negate(neg_b_in), .result(mag_b));

  // One iteration of each algorithm. The multiply sum keeps its carry so the
  // right shift brings it into the top of the accumulator. The divide compares
  // the (WIDTH+1)-bit shifted remainder; when it fits, the low WIDTH bits of
  // the difference are exact because the true difference is below the divisor.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_fits  = div_shift >= {1'b0, opnd};
  assign div_sub   = div_shift[WIDTH-1:0] - opnd;

  md_sign_fix #(.W(2*WIDTH)) u_fix_prod (.value({acc_hi, acc_lo}), .negate(neg_q), .result(prod_fix));
  md_sign_fix #(.W(WIDTH))   u_fix_quot (.value(acc_lo), .negate(neg_q), .result(quot_fix));
  md_sign_fix #(.W(WIDTH))   u_fix_rem  (.value(acc_hi), .negate(neg_r), .result(rem_fix));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic; MTHI/MTLO and invalid ops never leave IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && !(bus.op == MD_MTHI || bus.op == MD_MTLO))
              state_next = (FAST_MULT && op_is_mul(bus.op)) ? FIN : RUN;
      RUN:  if (cnt == LAST_CNT) state_next = FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture at accept, iteration in RUN, commit in FIN.
  // For divide by zero the remainder path ends holding the dividend magnitude,
  // so the normal remainder sign fix returns the raw operand for HI.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      opnd       <= '0;
      is_div_q   <= 1'b0;
      b_zero_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      hi_r       <= '0;
      lo_r       <= '0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (bus.op == MD_MTHI || bus.op == MD_MTLO) begin
            if (bus.op == MD_MTHI) hi_r <= bus.a;
            else                   lo_r <= bus.a;
            done_r     <= 1'b1;
            div_zero_r <= 1'b0;
          end else begin
            is_div_q <= op_is_div(bus.op);
            b_zero_q <= (bus.b == '0);
            neg_q    <= neg_a_in ^ neg_b_in;
            neg_r    <= neg_a_in;
            cnt      <= '0;
            if (op_is_div(bus.op)) begin
              opnd   <= mag_b;
              acc_hi <= '0;
              acc_lo <= mag_a;
            end else if (FAST_MULT) begin
              opnd             <= mag_a;
              {acc_hi, acc_lo} <= fast_prod;
            end else begin
              opnd   <= mag_a;
              acc_hi <= '0;
              acc_lo <= mag_b;
            end
          end
        end
        RUN: begin
          cnt <= (cnt == LAST_CNT) ? '0 : cnt + CNT_W'(1);
          if (is_div_q) begin
            acc_hi <= div_fits ? div_sub : div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_fits};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        FIN: begin
          done_r     <= 1'b1;
          div_zero_r <= is_div_q && b_zero_q;
          if (is_div_q) begin
            lo_r <= b_zero_q ? '1 : quot_fix;
            hi_r <= rem_fix;
          end else begin
            {hi_r, lo_r} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit (WIDTH=32).
// Drives requests on the falling edge, samples 1 ns after the rising edge.
// Latency is counted in rising edges from and including the accept edge.
module tb_mul_div_unit;
  import mul_div_pkg::*;

  localparam int WIDTH = 32;
`ifdef FAST_MULT_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  logic clk = 1'b0;
  logic reset_n;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  mul_div_if #(.WIDTH(WIDTH)) bus ();

  mul_div_unit #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    md_op_t      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic startOp(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Called 1 ns after the accept edge; polls for done with a bounded wait.
  task automatic waitDone(output int lat, output logic busy_gap, output logic busy_at_done);
    lat = 1;
    busy_gap = 1'b0;
    while (!bus.done && lat < 100) begin
      if (!bus.busy) busy_gap = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    busy_at_done = bus.busy;
    checkOutput("done_seen", {63'd0, bus.done}, 64'd1);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int   lat;
    logic gap, bad;
    startOp(v.op, v.a, v.b);
    waitDone(lat, gap, bad);
    checkOutput($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.lat));
    checkOutput($sformatf("v%0d_hi", idx), {32'd0, bus.hi}, {32'd0, v.hi});
    checkOutput($sformatf("v%0d_lo", idx), {32'd0, bus.lo}, {32'd0, v.lo});
    checkOutput($sformatf("v%0d_div_zero", idx), {63'd0, bus.div_zero}, {63'd0, v.dz});
    checkOutput($sformatf("v%0d_busy_held", idx), {63'd0, gap}, 64'd0);
    checkOutput($sformatf("v%0d_busy_at_done", idx), {63'd0, bad}, 64'd0);
  endtask

  task automatic watchCycles(input int n, output int dones, output int busies);
    dones = 0;
    busies = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
      if (bus.busy) busies++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   lat, dones, busies;
    logic gap, bad;

    vecs = '{
      '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, MUL_LAT},
      '{MD_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, MUL_LAT},
      '{MD_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, DIV_LAT},
      '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, DIV_LAT},
      '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, DIV_LAT},
      '{MD_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0, DIV_LAT},
      '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, DIV_LAT},
      '{MD_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1, DIV_LAT},
      '{MD_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, DIV_LAT},
      '{MD_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, DIV_LAT},
      '{MD_MULT,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, MUL_LAT},
      '{MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, MUL_LAT},
      '{MD_MULTU, 32'h0000ABCD, 32'h00001234, 32'h00000000, 32'h0C374FA4, 1'b0, MUL_LAT},
      '{MD_MTHI,  32'h12345678, 32'h00000000, 32'h12345678, 32'h0C374FA4, 1'b0, 1},
      '{MD_MTLO,  32'h9ABCDEF0, 32'h00000000, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1}
    };

    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.op    = MD_MULT;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hi", {32'd0, bus.hi}, 64'd0);
    checkOutput("reset_lo", {32'd0, bus.lo}, 64'd0);
    checkOutput("reset_busy", {63'd0, bus.busy}, 64'd0);
    checkOutput("reset_done", {63'd0, bus.done}, 64'd0);
    checkOutput("reset_div_zero", {63'd0, bus.div_zero}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Consecutive vectors start in the done cycle of the previous one.
    for (int i = 0; i < 15; i++) applyStimulus(vecs[i], i);

    // A request while busy must be dropped, not queued.
    startOp(MD_DIVU, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = MD_MULT;
    bus.a     = 32'd2;
    bus.b     = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    #6;
    waitDone(lat, gap, bad);
    checkOutput("busy_ignore_hi", {32'd0, bus.hi}, 64'd2);
    checkOutput("busy_ignore_lo", {32'd0, bus.lo}, 64'hE);
    watchCycles(40, dones, busies);
    checkOutput("busy_ignore_no_extra_done", 64'(dones), 64'd0);
    checkOutput("busy_ignore_no_extra_busy", 64'(busies), 64'd0);

    // Invalid encodings change nothing.
    startOp(md_op_t'(3'd6), 32'd5, 32'd3);
    watchCycles(5, dones, busies);
    startOp(md_op_t'(3'd7), 32'd5, 32'd3);
    watchCycles(40, dones, busies);
    checkOutput("invalid_op_done", 64'(dones), 64'd0);
    checkOutput("invalid_op_busy", 64'(busies), 64'd0);
    checkOutput("invalid_op_hi", {32'd0, bus.hi}, 64'd2);
    checkOutput("invalid_op_lo", {32'd0, bus.lo}, 64'hE);

    // Reset in the middle of a divide aborts it with no commit.
    startOp(MD_DIV, 32'hFFFFFFF9, 32'd2);
    repeat (9) @(posedge clk);
    #2;
    checkOutput("abort_busy_before", {63'd0, bus.busy}, 64'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_hi", {32'd0, bus.hi}, 64'd0);
    checkOutput("abort_lo", {32'd0, bus.lo}, 64'd0);
    checkOutput("abort_busy", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    watchCycles(40, dones, busies);
    checkOutput("abort_no_done", 64'(dones), 64'd0);
    checkOutput("abort_no_busy", 64'(busies), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised, multi-cycle HI/LO multiply/divide unit; successor to the single-cycle unsigned-only MULTU/DIVU path in the datapath ALU.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and owns the HI/LO architectural registers.
- Uses a start/busy/done handshake, so the CPU control FSM can stall on MFHI/MFLO until results are committed.
- Iterative radix-2 shift-add multiply and restoring division, one bit per cycle.

Parameters:
- WIDTH, 32, operand width and width of each of HI/LO; must be at least 4.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter; derived, not to be overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted on a rising edge when start=1 and busy=0.
- op  in  3  operation from mul_div_pkg::md_op_t; sampled at accept.
- a  in  WIDTH  rs operand / multiplicand / dividend / MTHI-MTLO source; sampled at accept.
- b  in  WIDTH  rt operand / multiplier / divisor; sampled at accept.
- busy  out  1  high while state != IDLE.
- done  out  1  registered one-cycle pulse when HI/LO are committed.
- div_zero  out  1  registered; valid with done; 1 when the completed DIV/DIVU had b==0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, hi=0, lo=0, done=0, div_zero=0, counter=0. Asserting reset mid-operation aborts the operation; no commit occurs.
- States:
  - IDLE: waiting for a request.
  - RUN: iterating for exactly WIDTH cycles; counter increments 0..WIDTH-1.
  - FIN: one cycle of sign correction and commit.
- Accept edge E0 (start & !busy & valid op):
  - MULT/MULTU/DIV/DIVU: latch operand magnitudes and result-sign flags; go to RUN.
  - Signed ops: magnitude is the two's-complement negate when the MSB is 1. The most-negative value negates to itself and is treated as unsigned 2^(WIDTH-1).
  - Unsigned ops: operands used as-is.
- RUN step, multiply: 2*WIDTH-bit accumulator; add multiplicand when the multiplier LSB is 1; shift right.
- RUN step, divide: shift {rem,quot} left 1; subtract divisor from rem; keep the subtraction and set the quotient bit when no borrow occurs.
- After the edge with counter==WIDTH-1, go to FIN.
- FIN edge (E_{WIDTH+1}):
  - Multiply: negate the 2*WIDTH product when the signs differ (MULT only); hi=upper half, lo=lower half.
  - Divide: quotient is negative when the signs differ; remainder takes the dividend's sign (DIV only). lo=quotient, hi=remainder.
  - done<=1 for one cycle; state<=IDLE.
- Latency: done is high, and hi/lo are valid, in the cycle after edge E_{WIDTH+1}; busy is low in that same cycle, so a back-to-back start is accepted there.
- MTHI/MTLO: at the accept edge, hi<=a or lo<=a respectively; no busy; done pulses the next cycle.
- Divide by zero (b==0, signed or unsigned): lo=all ones, hi=a (raw operand), div_zero=1. The unit still takes the full WIDTH+2 cycles.
- Overflow, DIV of most-negative by -1: lo=most-negative, hi=0 (natural wrap), div_zero=0.
- start while busy: ignored; no queueing.
- Invalid op encoding: ignored; no state change, no done.
- hi/lo hold their values at all times except at commit; MFHI/MFLO read them directly.

Optional Feature:
- FAST_MULT_EN defined: MULT/MULTU skip RUN and complete via a single-cycle WIDTH x WIDTH multiplier.
  - Sequence: accept edge -> FIN -> commit edge; done appears 2 cycles after accept.
  - Divide behaviour is unchanged.
- FAST_MULT_EN undefined: multiply is iterative, as specified under Behaviour.

Decomposition:
- Package mul_div_pkg contains:
  - md_op_t enum: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5; 6-7 invalid.
  - md_state_t enum: IDLE, RUN, FIN.
- One natural sub-module, md_sign_fix: combinational conditional-negate of a parametrised-width value. It is instantiated for operand magnitudes and result correction.

Test Plan (WIDTH=32):
- MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Without FAST_MULT_EN, done is seen exactly 34 cycles after the accept edge, and busy is high in between.
- MULT a=FFFFFFFD (-3), b=00000005 -> hi=FFFFFFFF, lo=FFFFFFF1. Back-to-back DIVU a=7, b=2 started in the done cycle -> lo=3, hi=1.
- DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0, div_zero=0.
- DIVU a=7, b=0 -> lo=FFFFFFFF, hi=00000007, div_zero=1. Next op clears div_zero at its done.
- MTHI a=12345678, then MTLO a=9ABCDEF0 -> hi/lo update at the accept edge; done one cycle later; busy stays 0.
- Start DIVU, pulse start with MULT while busy -> second request ignored. Assert reset_n=0 at cycle 10 of a DIV -> hi=lo=0, busy=0, no done.
